// File: rtl/div_issue_if.sv
// div_issue_if: request, divider and result channels of div_issue.
// slave is the issue stage's view; master is the surrounding environment.
interface div_issue_if;
   logic              req_valid;
   logic              req_ready;
   logic signed [7:0] req_dividend;
   logic signed [3:0] req_divisor;
   logic [1:0]        req_tag;
   logic              div_start;
   logic signed [7:0] div_word1;
   logic signed [3:0] div_word2;
   logic              div_ready;
   logic [3:0]        div_quotient;
   logic [3:0]        div_remainder;
   logic              res_valid;
   logic              res_ready;
   logic [3:0]        res_quotient;
   logic [3:0]        res_remainder;
   logic [1:0]        res_tag;
   logic              res_err;

   modport slave (
      input  req_valid, req_dividend, req_divisor, req_tag,
      input  div_ready, div_quotient, div_remainder, res_ready,
      output req_ready, div_start, div_word1, div_word2,
      output res_valid, res_quotient, res_remainder, res_tag, res_err
   );

   modport master (
      output req_valid, req_dividend, req_divisor, req_tag,
      output div_ready, div_quotient, div_remainder, res_ready,
      input  req_ready, div_start, div_word1, div_word2,
      input  res_valid, res_quotient, res_remainder, res_tag, res_err
   );
endinterface

// File: rtl/div_issue.sv
// div_issue: request FIFO, one-at-a-time issue to the sdiv divider and result capture.
// Optional DIV_ZERO_CHECK_EN: zero divisors bypass the divider and return res_err=1.
module div_issue #(
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        reset,
   div_issue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   typedef struct packed {
      logic signed [7:0] dividend;
      logic signed [3:0] divisor;
      logic [1:0]        tag;
   } req_t;

   req_t              fifo_mem [DEPTH];
   req_t              head;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   state_t            state_q, state_d;
   logic              div_start_q, div_start_d;
   logic signed [7:0] word1_q, word1_d;
   logic signed [3:0] word2_q, word2_d;
   logic [1:0]        tag_q, tag_d;
   logic              res_valid_q, res_valid_d;
   logic [3:0]        res_quot_q, res_quot_d;
   logic [3:0]        res_rem_q, res_rem_d;
   logic [1:0]        res_tag_q, res_tag_d;
`ifdef DIV_ZERO_CHECK_EN
   logic              res_err_q, res_err_d;
`endif
   logic              full, empty, push, pop, slot_free, can_issue;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   assign push      = bus.req_valid & bus.req_ready;
   assign head      = fifo_mem[rd_ptr_q];
   assign slot_free = ~res_valid_q | bus.res_ready;
   assign can_issue = (state_q == IDLE) & ~empty & bus.div_ready & slot_free;

   always_comb begin
      state_d     = state_q;
      div_start_d = 1'b0;
      word1_d     = word1_q;
      word2_d     = word2_q;
      tag_d       = tag_q;
      // A consumed result frees the slot; a load below on the same edge overrides this.
      res_valid_d = res_valid_q & ~bus.res_ready;
      res_quot_d  = res_quot_q;
      res_rem_d   = res_rem_q;
      res_tag_d   = res_tag_q;
`ifdef DIV_ZERO_CHECK_EN
      res_err_d   = res_err_q;
`endif
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (can_issue) begin
               pop = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
               if (head.divisor == '0) begin
                  res_valid_d = 1'b1;
                  res_quot_d  = 4'hF;
                  res_rem_d   = head.dividend[3:0];
                  res_tag_d   = head.tag;
                  res_err_d   = 1'b1;
               end else
`endif
               begin
                  word1_d     = head.dividend;
                  word2_d     = head.divisor;
                  tag_d       = head.tag;
                  div_start_d = 1'b1;
                  state_d     = START;
               end
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            if (bus.div_ready) begin
               res_valid_d = 1'b1;
               res_quot_d  = bus.div_quotient;
               res_rem_d   = bus.div_remainder;
               res_tag_d   = tag_q;
`ifdef DIV_ZERO_CHECK_EN
               res_err_d   = 1'b0;
`endif
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
      count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= '{bus.req_dividend, bus.req_divisor, bus.req_tag};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         div_start_q <= 1'b0;
         word1_q     <= '0;
         word2_q     <= '0;
         tag_q       <= '0;
         res_valid_q <= 1'b0;
         res_quot_q  <= '0;
         res_rem_q   <= '0;
         res_tag_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
         res_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         div_start_q <= div_start_d;
         word1_q     <= word1_d;
         word2_q     <= word2_d;
         tag_q       <= tag_d;
         res_valid_q <= res_valid_d;
         res_quot_q  <= res_quot_d;
         res_rem_q   <= res_rem_d;
         res_tag_q   <= res_tag_d;
`ifdef DIV_ZERO_CHECK_EN
         res_err_q   <= res_err_d;
`endif
      end
   end

   assign bus.req_ready     = reset & ~full;
   assign bus.div_start     = div_start_q;
   assign bus.div_word1     = word1_q;
   assign bus.div_word2     = word2_q;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_quotient  = res_quot_q;
   assign bus.res_remainder = res_rem_q;
   assign bus.res_tag       = res_tag_q;
`ifdef DIV_ZERO_CHECK_EN
   assign bus.res_err       = res_err_q;
`else
   assign bus.res_err       = 1'b0;
`endif
endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: drives div_issue against a cycle-level divider model and an
// in-order result scoreboard; table vectors, timing sequences and random traffic.
module tb_div_issue;
   localparam int DEPTH = 4;
`ifdef DIV_ZERO_CHECK_EN
   localparam bit ZCHK = 1'b1;
`else
   localparam bit ZCHK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   div_issue_if bus ();
   div_issue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cnt = 0;
   int res_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Signed truncating division; a zero divisor yields q=-1, r=dividend.
   function automatic logic [7:0] ref_div(input logic signed [7:0] a, input logic signed [3:0] b);
      int ai, bi, q, r;
      ai = a;
      bi = b;
      if (bi == 0) begin
         q = -1;
         r = ai;
      end else begin
         q = ai / bi;
         r = ai % bi;
      end
      return {q[3:0], r[3:0]};
   endfunction

   // Divider model: samples start, ready low for 4 edges, result with ready.
   logic       dv_rdy;
   logic [3:0] dv_q, dv_r;
   logic signed [7:0] dv_a;
   logic signed [3:0] dv_b;
   int         dv_cnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dv_rdy <= 1'b1;
         dv_cnt <= 0;
         dv_q   <= '0;
         dv_r   <= '0;
         dv_a   <= '0;
         dv_b   <= '0;
      end else if (bus.div_start) begin
         dv_rdy <= 1'b0;
         dv_cnt <= 4;
         dv_a   <= bus.div_word1;
         dv_b   <= bus.div_word2;
      end else if (dv_cnt != 0) begin
         dv_cnt <= dv_cnt - 1;
         if (dv_cnt == 1) begin
            dv_rdy       <= 1'b1;
            {dv_q, dv_r} <= ref_div(dv_a, dv_b);
         end
      end
   end
   assign bus.div_ready     = dv_rdy;
   assign bus.div_quotient  = dv_q;
   assign bus.div_remainder = dv_r;

   // Scoreboard: every accepted request yields one result, in acceptance order.
   typedef struct packed {
      logic [3:0] q;
      logic [3:0] r;
      logic [1:0] tag;
      logic       err;
   } res_t;
   res_t exp_q[$];

   function automatic res_t expect_of(input logic [7:0] a, input logic [3:0] b, input logic [1:0] tag);
      res_t e;
      logic [7:0] qr;
      qr    = ref_div(a, b);
      e.q   = qr[7:4];
      e.r   = qr[3:0];
      e.tag = tag;
      e.err = ZCHK && (b == 4'd0);
      return e;
   endfunction

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         exp_q.delete();
      end else begin
         if (bus.div_start) start_cnt++;
         if (bus.res_valid && bus.res_ready) begin
            res_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               res_t e;
               e = exp_q.pop_front();
               chk("sb_quotient", {28'd0, bus.res_quotient}, {28'd0, e.q});
               chk("sb_remainder", {28'd0, bus.res_remainder}, {28'd0, e.r});
               chk("sb_tag", {30'd0, bus.res_tag}, {30'd0, e.tag});
               chk("sb_err", {31'd0, bus.res_err}, {31'd0, e.err});
            end
         end
         if (bus.req_valid && bus.req_ready)
            exp_q.push_back(expect_of(bus.req_dividend, bus.req_divisor, bus.req_tag));
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [7:0] a, input logic [3:0] b, input logic [1:0] tag);
      logic acc;
      acc = 1'b0;
      bus.req_dividend = a;
      bus.req_divisor  = b;
      bus.req_tag      = tag;
      bus.req_valid    = 1'b1;
      for (int i = 0; i < 60 && !acc; i++) begin
         acc = bus.req_ready;
         step();
      end
      if (!acc) chk("push_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_res(output int n);
      n = 0;
      while (!bus.res_valid && n < 30) begin
         step();
         n++;
      end
   endtask

   function automatic logic [31:0] out_word();
      return {6'd0, bus.req_ready, bus.div_start, bus.div_word1, bus.div_word2, bus.res_valid,
              bus.res_quotient, bus.res_remainder, bus.res_tag, bus.res_err};
   endfunction

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [1:0] tag;
      logic [3:0] q;
      logic [3:0] r;
      bit         zdiv;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int n, s0, r0, acc_cnt, nres, hits, rand_acc;
      bit pending, acc;
      logic [1:0] tags[3];
      logic [7:0] qrs[3];
      int tcyc[3];

      vecs[0] = '{8'd20,  4'd3,  2'd1, 4'h6, 4'h2, 1'b0};
      vecs[1] = '{8'd45,  4'd7,  2'd0, 4'h6, 4'h3, 1'b0};
      vecs[2] = '{8'd9,   4'd2,  2'd2, 4'h4, 4'h1, 1'b0};
      vecs[3] = '{8'hEC,  4'd3,  2'd3, 4'hA, 4'hE, 1'b0};
      vecs[4] = '{8'd20,  4'hD,  2'd0, 4'hA, 4'h2, 1'b0};
      vecs[5] = '{8'hF9,  4'hE,  2'd1, 4'h3, 4'hF, 1'b0};
      vecs[6] = '{8'd7,   4'd7,  2'd2, 4'h1, 4'h0, 1'b0};
      vecs[7] = '{8'd0,   4'd5,  2'd3, 4'h0, 4'h0, 1'b0};
      vecs[8] = '{8'h35,  4'h0,  2'd3, 4'hF, 4'h5, 1'b1};
      vecs[9] = '{8'h80,  4'h0,  2'd1, 4'hF, 4'h0, 1'b1};

      bus.req_valid    = 1'b0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.req_tag      = '0;
      bus.res_ready    = 1'b0;

      // Reset: all outputs zero, req_ready low while asserted.
      #2 reset = 1'b0;
      repeat (3) step();
      chk("reset_outputs", out_word(), 32'd0);
      reset = 1'b1;
      #1;
      chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

      // Basic divide with latency checks.
      bus.res_ready = 1'b1;
      s0 = start_cnt;
      push_req(8'd20, 4'd3, 2'd1);
      step();
      chk("basic_start_k1", {31'd0, bus.div_start}, 32'd1);
      step();
      chk("basic_start_k2", {31'd0, bus.div_start}, 32'd0);
      repeat (4) step();
      chk("basic_valid_k6", {31'd0, bus.res_valid}, 32'd0);
      step();
      chk("basic_valid_k7", {31'd0, bus.res_valid}, 32'd1);
      chk("basic_result", {22'd0, bus.res_quotient, bus.res_remainder, bus.res_tag},
          {22'd0, 4'd6, 4'd2, 2'd1});
      chk("basic_err", {31'd0, bus.res_err}, 32'd0);
      step();
      chk("basic_start_count", start_cnt - s0, 32'd1);

      // Table vectors, one at a time.
      foreach (vecs[i]) begin
         s0 = start_cnt;
         push_req(vecs[i].a, vecs[i].b, vecs[i].tag);
         wait_res(n);
         chk("vec_latency", n, (ZCHK && vecs[i].zdiv) ? 32'd1 : 32'd7);
         chk("vec_result", {22'd0, bus.res_quotient, bus.res_remainder, bus.res_tag},
             {22'd0, vecs[i].q, vecs[i].r, vecs[i].tag});
         chk("vec_err", {31'd0, bus.res_err}, {31'd0, ZCHK && vecs[i].zdiv});
         chk("vec_starts", start_cnt - s0, (ZCHK && vecs[i].zdiv) ? 32'd0 : 32'd1);
         step();
      end

      // Ordering and back-to-back throughput.
      push_req(8'd45, 4'd7, 2'd0);
      push_req(8'd20, 4'd3, 2'd1);
      push_req(8'd9,  4'd2, 2'd2);
      nres = 0;
      for (int i = 0; i < 40 && nres < 3; i++) begin
         if (bus.res_valid) begin
            tags[nres] = bus.res_tag;
            qrs[nres]  = {bus.res_quotient, bus.res_remainder};
            tcyc[nres] = cyc;
            nres++;
         end
         step();
      end
      chk("order_count", nres, 32'd3);
      chk("order_tags", {26'd0, tags[0], tags[1], tags[2]}, {26'd0, 2'd0, 2'd1, 2'd2});
      chk("order_qr", {8'd0, qrs[0], qrs[1], qrs[2]}, {8'd0, 8'h63, 8'h62, 8'h41});
      chk("order_spacing1", tcyc[1] - tcyc[0], 32'd7);
      chk("order_spacing2", tcyc[2] - tcyc[1], 32'd7);

      // Backpressure: DEPTH queued plus one in flight, then a full-FIFO collision.
      repeat (2) step();
      r0 = res_seen;
      bus.res_ready = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         bus.req_dividend = 8'(i * 11 + 3);
         bus.req_divisor  = 4'(i + 1);
         bus.req_tag      = 2'(i);
         bus.req_valid    = 1'b1;
         if (bus.req_ready) acc_cnt++;
         step();
      end
      chk("bp_accepted", acc_cnt, DEPTH + 1);
      chk("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
      repeat (10) step();
      chk("bp_stall", {30'd0, bus.req_ready, bus.res_valid}, {30'd0, 1'b0, 1'b1});
      bus.res_ready = 1'b1;
      step();
      chk("full_pop_frees", {31'd0, bus.req_ready}, 32'd1);
      step();
      bus.req_valid = 1'b0;
      chk("full_refilled", {31'd0, bus.req_ready}, 32'd0);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      chk("bp_drained", exp_q.size(), 32'd0);
      chk("bp_result_count", res_seen - r0, 32'd6);

      // Reset while the divider is busy.
      step();
      push_req(8'd20, 4'd3, 2'd1);
      step();
      chk("rst_start", {31'd0, bus.div_start}, 32'd1);
      repeat (2) step();
      reset = 1'b0;
      #1;
      chk("rst_mid_outputs", out_word(), 32'd0);
      repeat (2) step();
      reset = 1'b1;
      hits = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (bus.res_valid) hits++;
      end
      chk("rst_no_result", hits, 32'd0);
      push_req(8'd9, 4'd2, 2'd2);
      wait_res(n);
      chk("rst_after_latency", n, 32'd7);
      chk("rst_after_result", {22'd0, bus.res_quotient, bus.res_remainder, bus.res_tag},
          {22'd0, 4'd4, 4'd1, 2'd2});
      step();

      // Random traffic against the scoreboard.
      r0 = res_seen;
      rand_acc = 0;
      pending = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!pending && ($urandom_range(0, 2) != 0)) begin
            bus.req_dividend = 8'($urandom);
            bus.req_divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            bus.req_tag      = 2'($urandom);
            bus.req_valid    = 1'b1;
            pending          = 1'b1;
         end
         bus.res_ready = ($urandom_range(0, 3) != 0);
         acc = bus.req_valid && bus.req_ready;
         step();
         if (acc) begin
            rand_acc++;
            pending       = 1'b0;
            bus.req_valid = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      bus.res_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      chk("rand_drained", exp_q.size(), 32'd0);
      chk("rand_result_count", res_seen - r0, rand_acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
